// File: rtl/simple_alu_seq.sv
// simple_alu_seq
//   Sequential ALU with a valid/ready handshake on both sides. Ops 000-110
//   are computed in the accept cycle and presented one cycle later. Op 111
//   (unsigned multiply) runs an MSB-first shift-add over WIDTH cycles in
//   the MUL state. The result and the {N,Z,C,V} flags are held in DONE
//   until the consumer takes them.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands/opcode presented
//   in_ready   high in IDLE only (forced low while rst is high)
//   a, b       operands, WIDTH bits
//   op         operation select (3 bits)
//   out_valid  high in DONE only (forced low while rst is high)
//   out_ready  consumer accepts the result
//   o          registered result, WIDTH bits
//   flags      registered {N, Z, C, V}
module simple_alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_FIRST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   o_reg, o_next;
  logic [3:0]         flags_reg, flags_next;

  // ---------------------------------------------------------------------
  // Single-cycle ALU, evaluated on the live inputs during the accept cycle
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  // Bit WIDTH of the extended difference is the borrow (a < b unsigned).
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      3'b000: alu_res = a;
      3'b001: alu_res = b;
      3'b010: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      3'b011: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      3'b100: alu_res = a & b;
      3'b101: alu_res = a | b;
      3'b110: alu_res = a ^ b;
      default: alu_res = '0; // multiply is handled by the MUL state
    endcase
  end

  assign alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};

  // ---------------------------------------------------------------------
  // Shift-add step: the counter doubles as the multiplier bit index, so
  // bits are consumed MSB first and the accumulator shifts left each step.
  // ---------------------------------------------------------------------
  logic               mul_bit;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] mul_step;
  logic [3:0]         mul_flags;

  assign mul_bit = b_reg[cnt_reg];

  generate
    for (genvar gi = 0; gi < 2 * WIDTH; gi++) begin : g_addend
      if (gi < WIDTH) begin : g_low
        assign addend[gi] = a_reg[gi] & mul_bit;
      end else begin : g_high
        assign addend[gi] = 1'b0;
      end
    end
  endgenerate

  assign mul_step  = {acc_reg[2*WIDTH-2:0], 1'b0} + addend;
  assign mul_flags = {mul_step[WIDTH-1], ~|mul_step[WIDTH-1:0],
                      |mul_step[2*WIDTH-1:WIDTH], 1'b0};

  // ---------------------------------------------------------------------
  // Next-state and datapath-next logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    o_next     = o_reg;
    flags_next = flags_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (op == 3'b111) begin
            a_next     = a;
            b_next     = b;
            cnt_next   = CNT_FIRST;
            acc_next   = '0;
            state_next = MUL;
          end else begin
            o_next     = alu_res;
            flags_next = alu_flags;
            state_next = DONE;
          end
        end
      end
      MUL: begin
        acc_next = mul_step;
        if (cnt_reg == '0) begin
          // Last multiplier bit: publish the low half straight from the step.
          o_next     = mul_step[WIDTH-1:0];
          flags_next = mul_flags;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      o_reg     <= '0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      o_reg     <= o_next;
      flags_reg <= flags_next;
    end
  end

  // Handshake outputs are masked by rst so nothing is offered or accepted
  // while reset is held.
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE) && !rst;
  assign o         = o_reg;
  assign flags     = flags_reg;

endmodule

// File: doc/simple_alu_seq.md
SIMPLE_ALU_SEQ -- requirements
Module: simple_alu_seq

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  operand/opcode presented.
REQ-005 Port: in_ready  output  1  block able to accept an operation.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: op  input  3  operation select; encoding in REQ-013.
REQ-009 Port: out_valid  output  1  result and flags valid.
REQ-010 Port: out_ready  input  1  downstream accepts the result.
REQ-011 Port: o  output  WIDTH  registered result.
REQ-012 Port: flags  output  4  registered {N, Z, C, V}, with N at bit 3.

Function
REQ-013 The op encoding SHALL be as follows.
- 000: o = a.
- 001: o = b.
- 010: o = a+b.
- 011: o = a-b.
- 100: o = a&b.
- 101: o = a|b.
- 110: o = a^b.
- 111: o = low WIDTH bits of a*b (unsigned).
REQ-014 An operation SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; a, b and op are captured on that edge only.
REQ-015 The FSM SHALL have exactly three states: IDLE, MUL, DONE.
REQ-016 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-017 Transitions from IDLE on accept SHALL be: op≠111 goes to DONE; op=111 goes to MUL. Without an accept, the FSM SHALL stay in IDLE.
REQ-018 Ops 000–110 SHALL have a latency of 1 cycle: out_valid rises on the edge after the accept edge.
REQ-019 MUL SHALL run an iterative shift-add, one multiplier bit per cycle, for exactly WIDTH cycles, using a counter from WIDTH-1 down to 0.
REQ-020 On counter=0 the FSM SHALL go to DONE, so MUL latency is WIDTH+1 cycles from accept to out_valid.
REQ-021 In DONE, o and flags SHALL hold stable until out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 in_valid SHALL be ignored outside IDLE.
REQ-024 Changes on a, b or op after the accept edge SHALL NOT affect the result.
REQ-025 Z SHALL be 1 when o is all zeros.
REQ-026 N SHALL equal o[WIDTH-1].
REQ-027 C SHALL be set as follows.
- Add: carry-out of bit WIDTH-1.
- Sub: borrow, i.e. 1 when a<b unsigned.
- Mul: 1 when the upper WIDTH bits of the 2*WIDTH product are nonzero.
- All other ops: 0.
REQ-028 V SHALL be set as follows.
- Add: two's-complement overflow, i.e. operand signs equal and result sign differs.
- Sub: operand signs differ and the result sign differs from a.
- All other ops: 0.
REQ-029 Add and sub SHALL wrap modulo 2^WIDTH.
REQ-030 The multiply accumulator SHALL be 2*WIDTH bits wide internally.
REQ-031 A back-to-back accept SHALL be possible no earlier than the cycle after DONE exits; with out_ready held at 1, a new op can be accepted every 2 cycles.
REQ-032 o and flags SHALL update only on the edge entering DONE; they keep their last value in IDLE and MUL.

Reset
REQ-033 When rst=1 at a rising edge, the FSM SHALL go to IDLE and o, flags, the MUL counter and the accumulator SHALL clear to 0.
REQ-034 Output values while rst=1 SHALL be: in_ready=0, out_valid=0.
REQ-035 in_ready SHALL be 1 on the first edge after rst is released.
REQ-036 rst SHALL take priority over in_valid and out_ready in every state.
REQ-037 A rst asserted mid-MUL or in DONE SHALL discard the pending result, with no out_valid pulse.

Verification (WIDTH=4)
REQ-038 Scenario: a=0111, b=0001, op=010 -> out_valid one cycle later, o=1000, flags N=1 Z=0 C=0 V=1.
REQ-039 Scenario: a=0011, b=0101, op=011 -> o=1110, flags N=1 Z=0 C=1 V=0; then a=0101, b=0101, op=011 -> o=0000, flags N=0 Z=1 C=0 V=0.
REQ-040 Scenario: a=0110, b=0011, op=111 -> in_ready=0 for 5 cycles, out_valid 5 cycles after accept, o=0010, flags N=0 Z=0 C=1 V=0; then a=0011, b=0101 -> o=1111, C=0.
REQ-041 Scenario: result held with out_ready=0 for 10 cycles while a, b, op and in_valid toggle -> o and flags are unchanged and no second accept occurs; out_ready=1 -> IDLE next edge.
REQ-042 Scenario: rst pulsed 2 cycles after a MUL accept -> out_valid never rises, o=0 and flags=0, in_ready=1 after release, and a following op=000 with a=1010 returns o=1010.
REQ-043 Scenario: op 100/101/110 with a=1100, b=1010 -> o=1000/1110/0110 respectively, C=V=0 in all three, and the bench completes with out_ready held at 1.
